// File: rtl/line_buffer_writer.sv
// Ping-pong line-buffer write controller: turns a valid/ready pixel stream into
// registered write strobes for two WIDTH-deep banks and tracks which bank is full.
module line_buffer_writer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 640,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [1:0]        bank_release,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [1:0]        bank_full,
    output logic              line_done,
    output logic              frame_done,
    output logic [15:0]       line_idx
);

    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(WIDTH - 1);
    localparam logic [15:0]       IDX_LAST = 16'(HEIGHT - 1);

    // Bit 1 of the encoding is the "full" flag, so bank_full comes straight off a flop.
    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'b00,
        BANK_FILLING = 2'b01,
        BANK_FULL    = 2'b10
    } bank_state_e;

    logic              cur_bank_q,   cur_bank_d;
    logic [ADDR_W-1:0] col_q,        col_d;
    logic [15:0]       line_idx_q,   line_idx_d;
    logic              wr_en_q,      wr_en_d;
    logic              wr_bank_q,    wr_bank_d;
    logic [ADDR_W-1:0] wr_addr_q,    wr_addr_d;
    logic [DATA_W-1:0] wr_data_q,    wr_data_d;
    logic              line_done_q,  line_done_d;
    logic              frame_done_q, frame_done_d;

    logic [1:0] bank_full_w;
    logic       accept;
    logic       line_end;

    assign in_ready = !bank_full_w[cur_bank_q];

    always_comb begin
        accept       = in_valid && in_ready;
        line_end     = accept && (col_q == COL_LAST);
        cur_bank_d   = cur_bank_q;
        col_d        = col_q;
        line_idx_d   = line_idx_q;
        wr_en_d      = accept;
        wr_bank_d    = wr_bank_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        line_done_d  = line_end;
        frame_done_d = 1'b0;

        if (accept) begin
            wr_bank_d = cur_bank_q;
            wr_addr_d = col_q;
            wr_data_d = in_data;
            col_d     = line_end ? '0 : col_q + ADDR_W'(1);
        end

        if (line_end) begin
            cur_bank_d = ~cur_bank_q;
            if (line_idx_q == IDX_LAST) begin
                line_idx_d   = '0;
                frame_done_d = 1'b1;
            end else begin
                line_idx_d = line_idx_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_bank_q   <= 1'b0;
            col_q        <= '0;
            line_idx_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_bank_q    <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cur_bank_q   <= cur_bank_d;
            col_q        <= col_d;
            line_idx_q   <= line_idx_d;
            wr_en_q      <= wr_en_d;
            wr_bank_q    <= wr_bank_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            line_done_q  <= line_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    // One small FSM per bank: FILLING -> FULL on its last pixel, FULL -> EMPTY or
    // straight back to FILLING on release, EMPTY -> FILLING when it becomes current.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        localparam logic BANK_ID = 1'(gi);
        localparam bank_state_e RESET_STATE = (gi == 0) ? BANK_FILLING : BANK_EMPTY;

        bank_state_e state_q, state_d;

        always_comb begin
            state_d = state_q;
            case (state_q)
                BANK_EMPTY: begin
                    if (cur_bank_d == BANK_ID) state_d = BANK_FILLING;
                end
                BANK_FILLING: begin
                    if (line_end && (cur_bank_q == BANK_ID)) state_d = BANK_FULL;
                end
                BANK_FULL: begin
                    if (bank_release[gi])
                        state_d = (cur_bank_d == BANK_ID) ? BANK_FILLING : BANK_EMPTY;
                end
                default: state_d = BANK_EMPTY;
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) state_q <= RESET_STATE;
            else       state_q <= state_d;
        end

        assign bank_full_w[gi] = state_q[1];
    end

    assign wr_en      = wr_en_q;
    assign wr_bank    = wr_bank_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign bank_full  = bank_full_w;
    assign line_done  = line_done_q;
    assign frame_done = frame_done_q;
    assign line_idx   = line_idx_q;

endmodule

// File: tb/tb_line_buffer_writer.sv
// Bench for line_buffer_writer: a 640x640 instance and an 8x4 instance checked every
// cycle against a pixel-count based reference model.
module tb_line_buffer_writer;

    localparam int W0 = 640, H0 = 640, W1 = 8, H1 = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid_s  [2];
    logic [7:0]  in_data_s   [2];
    logic [1:0]  rel_s       [2];
    logic        in_ready_s  [2];
    logic        wr_en_s     [2];
    logic        wr_bank_s   [2];
    logic [14:0] wr_addr_s   [2];
    logic [7:0]  wr_data_s   [2];
    logic [1:0]  bank_full_s [2];
    logic        line_done_s [2];
    logic        frame_done_s[2];
    logic [15:0] line_idx_s  [2];

    line_buffer_writer #(.WIDTH(W0), .HEIGHT(H0), .DATA_W(8), .ADDR_W(15)) dut0 (
        .clk(clk), .reset(rst), .in_valid(in_valid_s[0]), .in_data(in_data_s[0]),
        .in_ready(in_ready_s[0]), .bank_release(rel_s[0]), .wr_en(wr_en_s[0]),
        .wr_bank(wr_bank_s[0]), .wr_addr(wr_addr_s[0]), .wr_data(wr_data_s[0]),
        .bank_full(bank_full_s[0]), .line_done(line_done_s[0]),
        .frame_done(frame_done_s[0]), .line_idx(line_idx_s[0]));

    line_buffer_writer #(.WIDTH(W1), .HEIGHT(H1), .DATA_W(8), .ADDR_W(15)) dut1 (
        .clk(clk), .reset(rst), .in_valid(in_valid_s[1]), .in_data(in_data_s[1]),
        .in_ready(in_ready_s[1]), .bank_release(rel_s[1]), .wr_en(wr_en_s[1]),
        .wr_bank(wr_bank_s[1]), .wr_addr(wr_addr_s[1]), .wr_data(wr_data_s[1]),
        .bank_full(bank_full_s[1]), .line_done(line_done_s[1]),
        .frame_done(frame_done_s[1]), .line_idx(line_idx_s[1]));

    // Reference model: everything follows from the count of accepted pixels.
    int       m_n     [2];
    bit [1:0] m_full  [2];
    bit [1:0] m_rose  [2];
    bit       e_wr_en [2];
    bit       e_wr_bank[2];
    int       e_wr_addr[2];
    bit [7:0] e_wr_data[2];
    bit       e_ld    [2];
    bit       e_fd    [2];
    int       e_idx   [2];
    int       cd      [2][2];

    int n_cmp = 0;
    int n_err = 0;
    int ld_cnt, fd_cnt;
    int idx_q[$];

    function automatic int wid(input int i);
        return (i == 1) ? W1 : W0;
    endfunction

    function automatic int hgt(input int i);
        return (i == 1) ? H1 : H0;
    endfunction

    function automatic int cur_bank(input int i);
        return (m_n[i] / wid(i)) % 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_n[i] = 0; m_full[i] = 2'b00; m_rose[i] = 2'b00;
            e_wr_en[i] = 0; e_wr_bank[i] = 0; e_wr_addr[i] = 0; e_wr_data[i] = 8'h00;
            e_ld[i] = 0; e_fd[i] = 0; e_idx[i] = 0;
            cd[i][0] = -1; cd[i][1] = -1;
        end
    endtask

    task automatic check_outs(input int i);
        chk($sformatf("wr_en%0d", i),      32'(wr_en_s[i]),      32'(e_wr_en[i]));
        chk($sformatf("wr_bank%0d", i),    32'(wr_bank_s[i]),    32'(e_wr_bank[i]));
        chk($sformatf("wr_addr%0d", i),    32'(wr_addr_s[i]),    32'(e_wr_addr[i]));
        chk($sformatf("wr_data%0d", i),    32'(wr_data_s[i]),    32'(e_wr_data[i]));
        chk($sformatf("bank_full%0d", i),  32'(bank_full_s[i]),  32'(m_full[i]));
        chk($sformatf("line_done%0d", i),  32'(line_done_s[i]),  32'(e_ld[i]));
        chk($sformatf("frame_done%0d", i), 32'(frame_done_s[i]), 32'(e_fd[i]));
        chk($sformatf("line_idx%0d", i),   32'(line_idx_s[i]),   32'(e_idx[i]));
    endtask

    task automatic set_idle(input int i);
        in_valid_s[i] = 1'b0; in_data_s[i] = 8'h00; rel_s[i] = 2'b00;
    endtask

    // One clock: check in_ready before the edge, advance the model, check registers after.
    task automatic cycle();
        bit acc[2];
        int col, bank;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("in_ready%0d", i), 32'(in_ready_s[i]),
                32'(!m_full[i][cur_bank(i)]));
            acc[i] = in_valid_s[i] && !m_full[i][cur_bank(i)];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            m_rose[i] = 2'b00;
            m_full[i] = m_full[i] & ~rel_s[i];
            e_wr_en[i] = acc[i];
            e_ld[i] = 0;
            e_fd[i] = 0;
            if (acc[i]) begin
                col  = m_n[i] % wid(i);
                bank = cur_bank(i);
                e_wr_bank[i] = bank[0];
                e_wr_addr[i] = col;
                e_wr_data[i] = in_data_s[i];
                m_n[i]++;
                if (col == wid(i) - 1) begin
                    m_full[i][bank] = 1'b1;
                    m_rose[i][bank] = 1'b1;
                    e_ld[i]  = 1;
                    e_idx[i] = (m_n[i] / wid(i)) % hgt(i);
                    e_fd[i]  = (e_idx[i] == 0);
                    $display("inst%0d line complete: bank %0d line_idx %0d pixels %0d",
                             i, bank, e_idx[i], m_n[i]);
                end
            end
            check_outs(i);
        end
        if (line_done_s[1]) begin
            ld_cnt++;
            idx_q.push_back(int'(line_idx_s[1]));
        end
        if (frame_done_s[1]) fd_cnt++;
    endtask

    // Asynchronous reset asserted mid-cycle: outputs must clear without a clock edge.
    task automatic do_reset();
        set_idle(0);
        set_idle(1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            check_outs(i);
            chk($sformatf("rst_in_ready%0d", i), 32'(in_ready_s[i]), 32'd1);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) check_outs(i);
    endtask

    task automatic run_auto(input int i, input int cycles, input int pct, input int dly,
                            input bit spur);
        logic [1:0] rel;
        for (int c = 0; c < cycles; c++) begin
            in_valid_s[i] = ($urandom_range(99) < pct);
            in_data_s[i]  = 8'($urandom);
            rel = 2'b00;
            for (int b = 0; b < 2; b++) begin
                if (cd[i][b] > 0) cd[i][b]--;
                if (cd[i][b] == 0) begin
                    rel[b] = 1'b1;
                    cd[i][b] = -1;
                end
            end
            if (spur && ($urandom_range(99) < 3)) rel[$urandom_range(1)] = 1'b1;
            rel_s[i] = rel;
            cycle();
            for (int b = 0; b < 2; b++)
                if (m_rose[i][b]) cd[i][b] = dly;
        end
        set_idle(i);
    endtask

    task automatic push_pixels(input int i, input int count, input bit addr_data);
        for (int k = 0; k < count; k++) begin
            in_valid_s[i] = 1'b1;
            in_data_s[i]  = addr_data ? 8'(k) : 8'($urandom);
            cycle();
        end
        set_idle(i);
    endtask

    initial begin
        int exp_idx[4];
        exp_idx = '{1, 2, 3, 0};
        rst = 1'b1;
        set_idle(0);
        set_idle(1);
        do_reset();

        // Frame wrap on the 8x4 instance, releases one cycle after each line.
        ld_cnt = 0;
        fd_cnt = 0;
        idx_q.delete();
        run_auto(1, 32, 100, 1, 1'b0);
        chk("frame_line_done_count", 32'(ld_cnt), 32'd4);
        chk("frame_done_count", 32'(fd_cnt), 32'd1);
        chk("frame_idx_count", 32'(idx_q.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            if (k < idx_q.size()) chk($sformatf("frame_idx_%0d", k), 32'(idx_q[k]), 32'(exp_idx[k]));

        run_auto(1, 1500, 50, 10, 1'b1);

        // Single 640-pixel line, data = address.
        push_pixels(0, 640, 1'b1);
        chk("single_bank_full", 32'(bank_full_s[0]), 32'd1);
        chk("single_in_ready", 32'(in_ready_s[0]), 32'd1);

        // Second line fills bank 1, then stall with valid held.
        push_pixels(0, 640, 1'b0);
        push_pixels(0, 20, 1'b0);
        chk("both_bank_full", 32'(bank_full_s[0]), 32'd3);
        chk("both_in_ready", 32'(in_ready_s[0]), 32'd0);
        in_valid_s[0] = 1'b1;
        in_data_s[0]  = 8'h5a;
        rel_s[0]      = 2'b01;
        cycle();
        rel_s[0] = 2'b00;
        in_data_s[0] = 8'ha5;
        cycle();
        set_idle(0);
        chk("resume_wr_en", 32'(wr_en_s[0]), 32'd1);
        chk("resume_bank", 32'(wr_bank_s[0]), 32'd0);
        chk("resume_addr", 32'(wr_addr_s[0]), 32'd0);

        run_auto(0, 3000, 50, 10, 1'b1);

        // Reset at address 300 of bank 1.
        do_reset();
        push_pixels(0, 940, 1'b0);
        do_reset();
        in_valid_s[0] = 1'b1;
        in_data_s[0]  = 8'h3c;
        cycle();
        set_idle(0);
        chk("post_reset_wr_en", 32'(wr_en_s[0]), 32'd1);
        chk("post_reset_bank", 32'(wr_bank_s[0]), 32'd0);
        chk("post_reset_addr", 32'(wr_addr_s[0]), 32'd0);

        // Release of the empty bank on the last pixel of the filling bank.
        do_reset();
        push_pixels(0, 639, 1'b0);
        in_valid_s[0] = 1'b1;
        in_data_s[0]  = 8'h7e;
        rel_s[0]      = 2'b10;
        cycle();
        set_idle(0);
        chk("spurious_bank_full", 32'(bank_full_s[0]), 32'd1);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/line_buffer_writer.md
# line_buffer_writer

Ping-pong line-buffer write controller for the feature-map input path. It accepts a pixel stream over a valid/ready handshake and generates write enable, bank, address and data for two WIDTH-deep line banks. It marks each bank full when a complete line has been written and refills a bank only after the downstream column-counter consumer releases it. It is the producer side of the per-line read sequencing: one line is written while the other is read.

## Interface

**Parameters**
- WIDTH, 640: pixels per line.
- HEIGHT, 640: lines per frame.
- DATA_W, 8: pixel width.
- ADDR_W, 15: address/column counter width; must hold WIDTH-1.

**Ports**
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  upstream pixel valid.
- in_data  in  DATA_W  upstream pixel.
- in_ready  out  1  combinational: `!bank_full[cur_bank]`.
- bank_release  in  2  one-cycle pulse per bank; consumer has finished reading that bank.
- wr_en  out  1  registered write strobe.
- wr_bank  out  1  registered target bank.
- wr_addr  out  ADDR_W  registered column address, 0..WIDTH-1.
- wr_data  out  DATA_W  registered pixel.
- bank_full  out  2  registered; bank holds a complete unread line.
- line_done  out  1  one-cycle pulse; a line completed.
- frame_done  out  1  one-cycle pulse; line HEIGHT of the frame completed.
- line_idx  out  16  registered count of completed lines in the current frame.

## Operation

- **Accept:** a transfer occurs when `in_valid && in_ready`.
- **Per accepted pixel (next edge):**
  - wr_en=1, wr_bank=cur_bank, wr_addr=col, wr_data=in_data.
  - col increments.
- **No transfer:** wr_en=0; wr_bank, wr_addr and wr_data hold their last values.
- **Last pixel of a line (`col==WIDTH-1` on accept), same edge:**
  - col→0.
  - bank_full[cur_bank]→1.
  - cur_bank toggles.
  - line_done=1.
  - line_idx increments.
- **End of frame:** if line_idx was HEIGHT-1 at that edge, line_idx→0 and frame_done=1 (same cycle as line_done).
- **Release:** bank_release[b]=1 clears bank_full[b] on the next edge.
  - A release of a non-full bank is ignored.
  - Both bits may be released in one cycle.
- **Simultaneous set and release:** a set and a release can never target the same bank in the same cycle, because the bank being written is never full. A release of the other bank is applied normally.
- **Backpressure:** when cur_bank is full, in_ready=0 and col and line_idx hold. Stalls are unbounded.
- **Bank states:**
  - EMPTY (not full, not cur_bank).
  - FILLING (cur_bank, not full).
  - FULL.
  - A bank cycles FILLING → FULL → EMPTY/FILLING.
- **Counter widths:** col is ADDR_W bits and never exceeds WIDTH-1. line_idx is 16 bits and never exceeds HEIGHT-1.

## Timing

- **Reset values:** all outputs 0, cur_bank=0, col=0. in_ready is 1 immediately after reset deasserts.
- **Latency:** accepted pixel to wr_* is 1 cycle.
- **Bank full:** bank_full rises on the same edge that presents the final wr_en of that line. The memory captures that write on the following edge, so a consumer sampling bank_full may begin reading one cycle later.
- **Release to ready:** bank_release to in_ready rising is 1 cycle (bank_full register, then combinational in_ready).
- **Throughput:** maximum is 1 pixel/cycle. A full line takes WIDTH accepted cycles with no bubble at line boundaries when the next bank is empty.
- **Reset mid-line:** partial line discarded, both banks empty, bank 0 selected, col=0, line_idx=0. Any wr_en in flight is cleared.
- **Pulse widths:** line_done and frame_done are exactly one cycle.

## Test plan

- **Single line:** reset, then WIDTH=640 consecutive valid pixels (data=addr[7:0]), no releases.
  - wr_addr runs 0..639 on bank 0.
  - bank_full=2'b01 and line_done pulse on the cycle of addr 639.
  - in_ready remains 1, now targeting bank 1.
- **Both banks full:** continuous valid, no release.
  - After 1280 pixels bank_full=2'b11 and in_ready=0.
  - Further valid pixels produce no wr_en.
  - Pulse bank_release=2'b01: one cycle later in_ready=1 and writing resumes at bank 0, addr 0.
- **Random stalls:** in_valid at 50%, with releases issued 10 cycles after each bank_full.
  - wr_addr is strictly sequential with no skipped or duplicated addresses.
  - wr_data matches the accepted input order.
- **Frame wrap (HEIGHT=4, WIDTH=8):** 32 pixels with prompt releases.
  - line_done pulses 4 times; line_idx reads 1,2,3,0.
  - frame_done pulses once, together with the 4th line_done.
- **Reset mid-line:** assert reset at addr 300 of bank 1, then deassert.
  - All outputs 0.
  - The next accepted pixel is written to bank 0, addr 0.
- **Spurious release:** release an EMPTY bank in the same cycle as the last pixel of the other bank.
  - Only the filling bank becomes full; the empty bank stays 0.
